// File: rtl/seq_stage_controller_if.sv
// Handshake bundle between the SEQ stage controller and its datapath.
// master: controller side; slave: datapath / bench side.
interface seq_stage_controller_if #(
    parameter int unsigned CNT_W = 32
);
    logic             start;
    logic             step_mode;
    logic             clear;
    logic [3:0]       icode;
    logic [1:0]       status_f;
    logic [1:0]       status_m;
    logic             mem_done;
    logic             mem_req;
    logic [5:0]       stage_en;
    logic             pc_we;
    logic [1:0]       status;
    logic             halted;
    logic             busy;
    logic             err_timeout;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  start, step_mode, clear, icode, status_f, status_m, mem_done,
        output mem_req, stage_en, pc_we, status, halted, busy, err_timeout, cycle_cnt, instr_cnt
    );

    modport slave (
        output start, step_mode, clear, icode, status_f, status_m, mem_done,
        input  mem_req, stage_en, pc_we, status, halted, busy, err_timeout, cycle_cnt, instr_cnt
    );
endinterface

// File: rtl/seq_stage_controller.sv
// Multi-cycle control FSM for the Y86-64 SEQ datapath: one-hot stage enables,
// architectural status register, memory timeout, cycle/instruction counters.
module seq_stage_controller #(
    parameter int unsigned MEM_TIMEOUT = 8,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_stage_controller_if.master bus
);
    localparam int unsigned      WaitW   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CntMax  = '1;

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExecute, StMemory, StWriteback, StPcupd, StHalt
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       status_q, status_d;
    logic             err_q, err_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ins_q, ins_d;
    logic             active;

    function automatic logic is_mem_op(input logic [3:0] ic);
        return ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    endfunction

    assign active = (state_q != StIdle) && (state_q != StHalt);

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        err_d    = err_q;
        wait_d   = wait_q;
        cyc_d    = cyc_q;
        ins_d    = ins_q;
        if (active && (cyc_q != CntMax)) cyc_d = cyc_q + CNT_W'(1);
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StFetch;
                    cyc_d   = '0;
                    ins_d   = '0;
                end
            end
            StFetch: begin
                if (bus.status_f != 2'd0) begin
                    status_d = bus.status_f;
                    state_d  = StHalt;
                end else begin
                    state_d = StDecode;
                end
            end
            StDecode:  state_d = StExecute;
            StExecute: begin
                if (is_mem_op(bus.icode)) begin
                    state_d = StMemory;
                    wait_d  = WaitW'(1);
                end else begin
                    state_d = StWriteback;
                end
            end
            StMemory: begin
                // A completion on the timeout cycle still counts as success.
                if (bus.mem_done) begin
                    if (bus.status_m != 2'd0) begin
                        status_d = bus.status_m;
                        state_d  = StHalt;
                    end else begin
                        state_d = StWriteback;
                    end
                end else if (wait_q == WaitMax) begin
                    status_d = 2'd2;
                    err_d    = 1'b1;
                    state_d  = StHalt;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StWriteback: state_d = StPcupd;
            StPcupd: begin
                if (ins_q != CntMax) ins_d = ins_q + CNT_W'(1);
                state_d = bus.step_mode ? StIdle : StFetch;
            end
            StHalt: begin
                if (bus.clear) begin
                    state_d  = StIdle;
                    status_d = 2'd0;
                    err_d    = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            status_q <= 2'd0;
            err_q    <= 1'b0;
            wait_q   <= '0;
            cyc_q    <= '0;
            ins_q    <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            err_q    <= err_d;
            wait_q   <= wait_d;
            cyc_q    <= cyc_d;
            ins_q    <= ins_d;
        end
    end

    always_comb begin
        bus.stage_en = 6'b000000;
        unique case (state_q)
            StFetch:     bus.stage_en = 6'b000001;
            StDecode:    bus.stage_en = 6'b000010;
            StExecute:   bus.stage_en = 6'b000100;
            StMemory:    bus.stage_en = 6'b001000;
            StWriteback: bus.stage_en = 6'b010000;
            StPcupd:     bus.stage_en = 6'b100000;
            default:     bus.stage_en = 6'b000000;
        endcase
    end

    assign bus.mem_req     = (state_q == StMemory);
    assign bus.pc_we       = (state_q == StPcupd) && (status_q == 2'd0);
    assign bus.halted      = (state_q == StHalt);
    assign bus.busy        = active;
    assign bus.status      = status_q;
    assign bus.err_timeout = err_q;
    assign bus.cycle_cnt   = cyc_q;
    assign bus.instr_cnt   = ins_q;
endmodule

// File: tb/tb_seq_stage_controller.sv
// Bench for seq_stage_controller: directed scenarios plus random instruction
// streams checked against a per-instruction stage-trace reference model.
module tb_seq_stage_controller;
    localparam int unsigned MT = 8;
    localparam int unsigned CW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_stage_controller_if #(.CNT_W(CW)) bus ();

    seq_stage_controller #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned m_cycles, m_instrs;
    logic [1:0]  m_status;
    logic        m_err;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_mem(input logic [3:0] ic);
        return ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Outputs expected while parked in IDLE (exp_halt=0) or HALT (exp_halt=1).
    task automatic check_quiet(input bit exp_halt);
        check_eq("q_stage_en", bus.stage_en, 6'h00);
        check_eq("q_mem_req", bus.mem_req, 1'b0);
        check_eq("q_pc_we", bus.pc_we, 1'b0);
        check_eq("q_busy", bus.busy, 1'b0);
        check_eq("q_halted", bus.halted, exp_halt);
        check_eq("q_status", bus.status, m_status);
        check_eq("q_err_timeout", bus.err_timeout, m_err);
        check_eq("q_cycle_cnt", bus.cycle_cnt, m_cycles);
        check_eq("q_instr_cnt", bus.instr_cnt, m_instrs);
    endtask

    task automatic start_run(input bit step);
        bus.step_mode = step;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        m_cycles  = 0;
        m_instrs  = 0;
    endtask

    task automatic do_clear();
        check_quiet(1'b1);
        bus.start = 1'b1;
        tick();
        tick();
        bus.start = 1'b0;
        check_quiet(1'b1);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        m_status  = 2'd0;
        m_err     = 1'b0;
        check_quiet(1'b0);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check_quiet(1'b0);
    endtask

    // Builds the expected stage sequence for one instruction and walks it.
    // lat: MEMORY cycle on which mem_done is raised (beyond MT means never).
    task automatic exec_instr(input logic [3:0] ic, input logic [1:0] sf, input int lat,
                              input logic [1:0] sm, output bit halted_o);
        logic [5:0] trace[$];
        logic [1:0] fault;
        bit         tmo;
        int         mem_seen;
        int         n_mem;
        fault    = 2'd0;
        tmo      = 1'b0;
        mem_seen = 0;
        trace.push_back(6'h01);
        if (sf != 2'd0) begin
            fault = sf;
        end else begin
            trace.push_back(6'h02);
            trace.push_back(6'h04);
            if (is_mem(ic)) begin
                n_mem = (lat > int'(MT)) ? int'(MT) : lat;
                for (int j = 0; j < n_mem; j++) trace.push_back(6'h08);
                if (lat > int'(MT)) begin
                    fault = 2'd2;
                    tmo   = 1'b1;
                end else if (sm != 2'd0) begin
                    fault = sm;
                end
            end
            if (fault == 2'd0) begin
                trace.push_back(6'h10);
                trace.push_back(6'h20);
            end
        end
        foreach (trace[i]) begin
            bus.icode    = ic;
            bus.status_f = (i == 0) ? sf : 2'($urandom_range(0, 3));
            bus.mem_done = 1'b0;
            bus.status_m = 2'($urandom_range(0, 3));
            if (trace[i] == 6'h08) begin
                mem_seen++;
                if (mem_seen == lat) begin
                    bus.mem_done = 1'b1;
                    bus.status_m = sm;
                end
            end
            check_eq("stage_en", bus.stage_en, trace[i]);
            check_eq("mem_req", bus.mem_req, trace[i] == 6'h08);
            check_eq("pc_we", bus.pc_we, trace[i] == 6'h20);
            check_eq("busy", bus.busy, 1'b1);
            check_eq("halted", bus.halted, 1'b0);
            check_eq("status_run", bus.status, 2'd0);
            check_eq("cycle_cnt", bus.cycle_cnt, m_cycles);
            tick();
            m_cycles++;
        end
        bus.mem_done = 1'b0;
        if (fault != 2'd0) begin
            m_status = fault;
            m_err    = tmo;
            halted_o = 1'b1;
        end else begin
            m_instrs++;
            halted_o = 1'b0;
            check_eq("instr_cnt", bus.instr_cnt, m_instrs);
            if (bus.step_mode) check_quiet(1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit         h;
        bit         step;
        logic [3:0] ic;
        logic [1:0] sf, sm;
        int         lat;

        bus.start = 1'b0; bus.step_mode = 1'b0; bus.clear = 1'b0; bus.icode = 4'h0;
        bus.status_f = 2'd0; bus.status_m = 2'd0; bus.mem_done = 1'b0;
        m_cycles = 0; m_instrs = 0; m_status = 2'd0; m_err = 1'b0;
        tick();
        tick();
        check_quiet(1'b0);
        rst_n = 1'b1;
        tick();
        check_quiet(1'b0);

        // Free-running non-memory instructions, then a fetch fault to stop.
        start_run(1'b0);
        exec_instr(4'h6, 2'd0, 1, 2'd0, h);
        exec_instr(4'h6, 2'd0, 1, 2'd0, h);
        check_eq("two_instr_cycles", bus.cycle_cnt, 10);
        check_eq("two_instr_count", bus.instr_cnt, 2);
        exec_instr(4'h0, 2'd1, 1, 2'd0, h);
        do_clear();

        // call with mem_done on the third MEMORY cycle
        start_run(1'b1);
        exec_instr(4'h8, 2'd0, 3, 2'd0, h);
        check_eq("call_cycles", bus.cycle_cnt, 8);

        start_run(1'b1);
        exec_instr(4'h0, 2'd1, 1, 2'd0, h);
        check_eq("hlt_instr_cnt", bus.instr_cnt, 0);
        do_clear();

        // Memory timeout, then completion exactly on the last allowed cycle.
        start_run(1'b1);
        exec_instr(4'h5, 2'd0, MT + 1, 2'd0, h);
        check_eq("timeout_err", bus.err_timeout, 1'b1);
        do_clear();
        start_run(1'b1);
        exec_instr(4'h5, 2'd0, MT, 2'd0, h);
        check_eq("edge_no_err", bus.err_timeout, 1'b0);

        start_run(1'b0);
        exec_instr(4'hA, 2'd0, 1, 2'd3, h);
        check_eq("ins_status", bus.status, 2'd3);
        do_clear();

        // Asynchronous reset in EXECUTE.
        start_run(1'b1);
        bus.icode = 4'h5; bus.status_f = 2'd0;
        tick();
        tick();
        check_eq("pre_rst_exec", bus.stage_en, 6'h04);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_stage_en", bus.stage_en, 6'h00);
        check_eq("arst_busy", bus.busy, 1'b0);
        check_eq("arst_pc_we", bus.pc_we, 1'b0);
        check_eq("arst_cycle_cnt", bus.cycle_cnt, 0);
        bus.start = 1'b1;
        tick();
        tick();
        check_eq("arst_start_ignored", bus.busy, 1'b0);
        check_eq("arst_no_pc_we", bus.pc_we, 1'b0);
        bus.start = 1'b0;
        m_cycles = 0; m_instrs = 0; m_status = 2'd0; m_err = 1'b0;
        rst_n = 1'b1;
        tick();
        check_quiet(1'b0);

        for (int ep = 0; ep < 40; ep++) begin
            step = 1'($urandom_range(0, 1));
            h    = 1'b0;
            for (int k = 0; k < 6 && !h; k++) begin
                if (step || k == 0) start_run(step);
                ic  = 4'($urandom_range(0, 15));
                sf  = (ic == 4'h0) ? 2'd1 :
                      (($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0);
                lat = $urandom_range(1, MT + 1);
                sm  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
                exec_instr(ic, sf, lat, sm, h);
            end
            if (!h && !step) exec_instr(4'h0, 2'd1, 1, 2'd0, h);
            if (h) do_clear();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
